// File: rtl/qlog2_pkg.sv
// qlog2_pkg: shared types, iteration count and leading-one detect for qlog2_seq (QLOG2_ROUND_EN adds a guard iteration)
package qlog2_pkg;

    typedef enum logic [2:0] {IDLE, NORM, SQUARE, FIX, DONE} state_t;

    localparam int Q_DEF = 8;
    localparam int N_DEF = 16;

`ifdef QLOG2_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    localparam int ITERS = Q_DEF + GUARD;
    localparam int CNT_W = $clog2(ITERS + 1);

    function automatic int lod(input logic [31:0] v);
        int p;
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        return p;
    endfunction

endpackage

// File: rtl/qmult.sv
// qmult: combinational sign-magnitude Q-format multiplier with truncated fraction and overflow flag
module qmult #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         ena,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         ovr
);

    logic [2*N-3-Q:0] sh;

    assign sh     = (2*N-2-Q)'(((2*N-2)'(a[N-2:0]) * (2*N-2)'(b[N-2:0])) >> Q);
    assign result = ena ? {a[N-1] ^ b[N-1], sh[N-2:0]} : '0;
    assign ovr    = ena & (|sh[2*N-3-Q:N-1]);

endmodule

// File: rtl/qlog2_seq.sv
// qlog2_seq: sequential log2 by normalise + repeated squaring; QLOG2_ROUND_EN adds a guard bit and round-half-up
module qlog2_seq
    import qlog2_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_x,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_err
);

    localparam int IT = Q + GUARD;
    localparam int CW = $clog2(IT + 1);

    state_t              state, next;
    logic [N-1:0]        x, sq_p;
    logic signed [N-1:0] k, r;
    logic [N-2:0]        y, y_n;
    logic [CW-1:0]       cnt;
    logic [IT-1:0]       frac;
    logic                sq_ovr, hi, err;
    int                  p;

    qmult #(.Q(Q), .N(N)) u_sq (
        .ena    (1'b1),
        .a      ({1'b0, y}),
        .b      ({1'b0, y}),
        .result (sq_p),
        .ovr    (sq_ovr)
    );

    assign o_ready = state == IDLE;
    assign o_valid = state == DONE;

    // normalisation, squaring decision and final fixed-point sum (overflow implies a value >= 2)
    always_comb begin
        p   = lod(32'(x[N-2:0]));
        err = x[N-1] | ~(|x[N-2:0]);
        y_n = (p >= Q) ? x[N-2:0] >> (p - Q) : x[N-2:0] << (Q - p);
        hi  = sq_p[Q+1] | sq_ovr;
`ifdef QLOG2_ROUND_EN
        r   = (k <<< Q) + N'(frac[IT-1:1]) + N'(frac[0]);
`else
        r   = (k <<< Q) + N'(frac);
`endif
    end

    // next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = i_valid ? NORM : IDLE;
            NORM:    next = err ? DONE : SQUARE;
            SQUARE:  next = (cnt == CW'(IT - 1)) ? FIX : SQUARE;
            FIX:     next = DONE;
            DONE:    next = i_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // datapath: capture, normalise, shift result bits in MSB-first, convert to sign-magnitude
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            k        <= '0;
            cnt      <= '0;
            frac     <= '0;
            o_result <= '0;
            o_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) x <= i_x;
                NORM: begin
                    if (err) begin
                        o_err    <= 1'b1;
                        o_result <= '0;
                    end else begin
                        y    <= y_n;
                        k    <= N'(p - Q);
                        cnt  <= '0;
                        frac <= '0;
                    end
                end
                SQUARE: begin
                    y    <= hi ? sq_p[N-1:1] : sq_p[N-2:0];
                    frac <= {frac[IT-2:0], hi};
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    o_result <= r[N-1] ? {1'b1, (N-1)'(-r)} : r;
                    o_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
